// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: start/busy/done handshake and operand/result bus of the serial adder
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
  logic start, cin, busy, done, cout;
  logic [WIDTH-1:0] a, b, sum;
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder, LSB first through a carry flop, start/busy/done handshake
module serial_adder_ctrl #(parameter int WIDTH = 8) (
  input logic ck,
  input logic rst_n,
  serial_adder_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, acc, sum_r;
  logic [CW-1:0] cnt;
  logic carry, cout_r, fa_s, fa_c, last;
  assign fa_s = a_sh[0] ^ b_sh[0] ^ carry;
  assign fa_c = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  assign last = cnt == CW'(WIDTH - 1);
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.sum = sum_r;
  assign bus.cout = cout_r;
  always_ff @(posedge ck or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (state == IDLE && bus.start) state_nxt = RUN;
    if (state == RUN && last) state_nxt = DONE;
    if (state == DONE) state_nxt = IDLE;
  end
  // the final sum includes the bit produced on the completing edge, hence fa_s joins acc directly
  always_ff @(posedge ck or negedge rst_n)
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      acc <= '0;
      sum_r <= '0;
      cnt <= '0;
      carry <= 1'b0;
      cout_r <= 1'b0;
    end else if (state == IDLE && bus.start) begin
      a_sh <= bus.a;
      b_sh <= bus.b;
      carry <= bus.cin;
      cnt <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      acc <= {fa_s, acc[WIDTH-1:1]};
      carry <= fa_c;
      cnt <= cnt + 1'b1;
      if (last) begin
        sum_r <= {fa_s, acc[WIDTH-1:1]};
        cout_r <= fa_c;
      end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: scoreboard bench for 8-bit and 2-bit serial adders against a + b + cin
module tb_serial_adder_ctrl;
  typedef struct {logic [32:0] r; int c;} exp_t;
  logic ck = 1'b0;
  logic rst_n;
  int cyc = 0, errs = 0, checks = 0;
  exp_t q8[$], q2[$];
  exp_t e8, e2;
  logic [32:0] last8 = '0, last2 = '0;
  logic [7:0] la, lb;
  logic lc;
  serial_adder_ctrl_if #(.WIDTH(8)) b8();
  serial_adder_ctrl_if #(.WIDTH(2)) b2();
  serial_adder_ctrl #(.WIDTH(8)) u8 (.ck(ck), .rst_n(rst_n), .bus(b8.slave));
  serial_adder_ctrl #(.WIDTH(2)) u2 (.ck(ck), .rst_n(rst_n), .bus(b2.slave));
  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge ck)
    if (!rst_n) last8 = '0;
    else if (b8.done) begin
      chk("overlap8", {32'b0, b8.busy}, 33'd0);
      if (q8.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL done8: unexpected done pulse sum=%h", b8.sum);
      end else begin
        e8 = q8.pop_front();
        chk("sum8", {24'b0, b8.cout, b8.sum}, e8.r);
        chk("lat8", 33'(cyc), 33'(e8.c + 8));
        last8 = e8.r;
      end
    end else chk("hold8", {24'b0, b8.cout, b8.sum}, last8);
  always @(negedge ck)
    if (!rst_n) last2 = '0;
    else if (b2.done) begin
      chk("overlap2", {32'b0, b2.busy}, 33'd0);
      if (q2.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL done2: unexpected done pulse sum=%h", b2.sum);
      end else begin
        e2 = q2.pop_front();
        chk("sum2", {30'b0, b2.cout, b2.sum}, e2.r);
        chk("lat2", 33'(cyc), 33'(e2.c + 2));
        last2 = e2.r;
      end
    end else chk("hold2", {30'b0, b2.cout, b2.sum}, last2);
  task automatic wait_idle8();
    int n = 0;
    while ((b8.busy || b8.done) && n < 40) begin
      @(negedge ck);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errs++;
      $display("FAIL idle8: timed out busy=%b done=%b", b8.busy, b8.done);
    end
  endtask
  task automatic wait_idle2();
    int n = 0;
    while ((b2.busy || b2.done) && n < 20) begin
      @(negedge ck);
      n++;
    end
    if (n >= 20) begin
      checks++;
      errs++;
      $display("FAIL idle2: timed out busy=%b done=%b", b2.busy, b2.done);
    end
  endtask
  task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c);
    wait_idle8();
    b8.a = a;
    b8.b = b;
    b8.cin = c;
    b8.start = 1'b1;
    @(posedge ck);
    @(negedge ck);
    b8.start = 1'b0;
    b8.a = 8'($urandom);
    b8.b = 8'($urandom);
    b8.cin = 1'($urandom);
    q8.push_back('{r: {24'b0, 9'(a) + 9'(b) + 9'(c)}, c: cyc});
    chk("busy8", {31'b0, b8.busy, b8.done}, 33'b10);
  endtask
  task automatic add2(input logic [1:0] a, input logic [1:0] b, input logic c);
    wait_idle2();
    b2.a = a;
    b2.b = b;
    b2.cin = c;
    b2.start = 1'b1;
    @(posedge ck);
    @(negedge ck);
    b2.start = 1'b0;
    b2.a = 2'($urandom);
    b2.b = 2'($urandom);
    b2.cin = 1'($urandom);
    q2.push_back('{r: {30'b0, 3'(a) + 3'(b) + 3'(c)}, c: cyc});
    chk("busy2", {31'b0, b2.busy, b2.done}, 33'b10);
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    {b8.start, b8.a, b8.b, b8.cin} = '0;
    {b2.start, b2.a, b2.b, b2.cin} = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge ck);
    chk("rst8", {22'b0, b8.busy, b8.done, b8.cout, b8.sum}, 33'd0);
    chk("rst2", {28'b0, b2.busy, b2.done, b2.cout, b2.sum}, 33'd0);
    rst_n = 1'b1;
    @(negedge ck);
    add8(8'h5A, 8'h33, 1'b0);
    add8(8'hFF, 8'h01, 1'b0);
    add8(8'hFF, 8'hFF, 1'b1);
    add8(8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) add8(8'($urandom), 8'($urandom), 1'($urandom));
    // start held high: accepts land every WIDTH+2 edges, operands sampled only then
    wait_idle8();
    {la, lb, lc} = 17'($urandom);
    {b8.a, b8.b, b8.cin} = {la, lb, lc};
    b8.start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge ck);
      @(negedge ck);
      if (k % 10 == 0) q8.push_back('{r: {24'b0, 9'(la) + 9'(lb) + 9'(lc)}, c: cyc});
      {la, lb, lc} = 17'($urandom);
      {b8.a, b8.b, b8.cin} = {la, lb, lc};
    end
    b8.start = 1'b0;
    // reset in the middle of a run discards it without a done pulse
    add8(8'($urandom), 8'($urandom), 1'($urandom));
    repeat (3) @(negedge ck);
    #2 rst_n = 1'b0;
    q8.delete();
    #1 chk("midrst8", {22'b0, b8.busy, b8.done, b8.cout, b8.sum}, 33'd0);
    @(posedge ck);
    @(negedge ck);
    #2 rst_n = 1'b1;
    @(negedge ck);
    add8(8'd3, 8'd4, 1'b0);
    for (int i = 0; i < 32; i++) add2(2'(i >> 2), 2'(i), 1'(i >> 4));
    repeat (20) @(negedge ck);
    chk("drain8", 33'(q8.size()), 33'd0);
    chk("drain2", 33'(q2.size()), 33'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
